// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial wide adder sequencer.
package serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sadd_state_t;

endpackage

// File: rtl/simple_8bit_adder.sv
// Registered 8-bit adder with carry in/out: sum and cout appear one cycle after a/b/cin.
module simple_8bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] res_q, res_d;

  always_comb begin
    res_d = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign sum  = res_q[7:0];
  assign cout = res_q[8];

endmodule

// File: rtl/serial_wide_add_ctrl.sv
// Byte-serial sequencer that drives an external registered 8-bit adder LSB first and gathers a W-bit sum.
// Optional signed-overflow output out_ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_wide_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0]   in_a,
  input  logic [BYTE_W*NUM_BYTES-1:0]   in_b,
  input  logic                          in_cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0]   out_sum,
  output logic                          out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic                          out_ovf,
`endif
  output logic [BYTE_W-1:0]             add_a,
  output logic [BYTE_W-1:0]             add_b,
  output logic                          add_cin,
  input  logic [BYTE_W-1:0]             add_sum,
  input  logic                          add_cout
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  sadd_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cin_q, cin_d, cout_q, cout_d, valid_q, valid_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign in_ready = (state_q == S_IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_a = a_q[BYTE_W*idx_q +: BYTE_W];
        add_b = b_q[BYTE_W*idx_q +: BYTE_W];
        // The adder's registered carry from the previous byte is already on add_cout this cycle.
        add_cin = (idx_q == '0) ? cin_q : add_cout;
        if (idx_q != '0) sum_d[BYTE_W*(idx_q - 1'b1) +: BYTE_W] = add_sum;
        if (idx_q == LAST_IDX) state_d = S_DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DRAIN: begin
        sum_d[W-1 -: BYTE_W] = add_sum;
        cout_d  = add_cout;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[BYTE_W-1] != a_q[W-1]);
`endif
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_wide_add_ctrl.sv
// Scoreboard bench for serial_wide_add_ctrl with the registered 8-bit adder alongside.
module tb_serial_wide_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;
`endif
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  serial_wide_add_ctrl #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf(out_ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  simple_8bit_adder u_adder (
    .clk(clk), .rst(rst),
    .a(add_a), .b(add_b), .cin(add_cin),
    .sum(add_sum), .cout(add_cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_sent = 0;
  int           n_done = 0;
  int           ready_mode = 0;
  bit           scramble = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: wide integer add, plus signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    res_t         r;
    logic [W:0]   full;
    longint       s;
    longint       lim;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    s      = longint'($signed(a)) + longint'($signed(b)) + (cin ? 64'sd1 : 64'sd0);
    lim    = 64'sd1 <<< (W - 1);
    r.ovf  = (s >= lim) || (s < -lim);
    return r;
  endfunction

  // Holds in_valid until accepted; busy cycles optionally see garbage operands.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        in_a = a; in_b = b; in_cin = cin;
        @(posedge clk);
        sb.push_back(model(a, b, cin));
        n_sent++;
        #1 in_valid = 1'b0;
        if (scramble) begin in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); end
        return;
      end else if (scramble) begin
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
      end
    end
    n_vec++; n_err++;
    $display("FAIL accept_timeout: in_ready never rose for a=0x%0h b=0x%0h", a, b);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // out_ready changes just after the rising edge so it is stable around sampling points.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compare every presented result against the scoreboard head, pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_result: got sum 0x%0h with nothing outstanding", out_sum);
      end else begin
        check("out_sum", 64'(out_sum), 64'(sb[0].sum));
        check("out_cout", 64'(out_cout), 64'(sb[0].cout));
`ifdef SERIAL_ADD_OVF_EN
        check("out_ovf", 64'(out_ovf), 64'(sb[0].ovf));
`endif
        check("in_ready_while_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          last_sum  = out_sum;
          last_cout = out_cout;
`ifdef SERIAL_ADD_OVF_EN
          last_ovf  = out_ovf;
`endif
          void'(sb.pop_front());
          n_done++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Byte carry into byte 1, and accept-to-valid latency.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency_edges", 64'(lat), 64'(NB + 1));
    wait_drain();
    check("t1_sum", 64'(last_sum), 64'h0000_0100);
    check("t1_cout", 64'(last_cout), 64'd0);

    // Carry-in rippling through every byte.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_drain();
    check("t2_sum", 64'(last_sum), 64'h0);
    check("t2_cout", 64'(last_cout), 64'd1);

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_drain();
    check("t3_sum", 64'(last_sum), 64'h8000_0000);
    check("t3_cout", 64'(last_cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("t3_ovf", 64'(last_ovf), 64'd1);
`endif

    // Downstream stall with a second operand pair pending.
    ready_mode = 2;
    send(32'h0000_1234, 32'h0000_4321, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    fork
      send(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_pending", 64'(sb.size()), 64'd1);
        end
        ready_mode = 0;
      end
    join
    wait_drain();
    check("t4_sum", 64'(last_sum), 64'h0);
    check("t4_cout", 64'(last_cout), 64'd1);

    // Reset while the third byte is being issued.
    send(32'hAAAA_5555, 32'h0000_1234, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_add_a", 64'(add_a), 64'd0);
    void'(sb.pop_back());
    n_sent--;
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_drain();
    check("t5_sum", 64'(last_sum), 64'h2345_6789);
    check("t5_cout", 64'(last_cout), 64'd0);

    // Random operands with random gaps, busy-time garbage and downstream stalls.
    ready_mode = 1;
    scramble   = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = ~ra;
        2: begin ra = 32'h7FFF_FFFF; rb = $urandom_range(0, 3); end
        3: begin ra = 32'h8000_0000; rb = 32'h8000_0000 | rb; end
        default: ;
      endcase
      send(ra, rb, 1'($urandom));
    end
    wait_drain();
    ready_mode = 0;
    check("results_returned", 64'(n_done), 64'(n_sent));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
